fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16, data word width matching the FIFO write port.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of producers sharing the FIFO write port (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-producer write request, level-held.
REQ-006 SHALL have port req_data  input  NUM_REQ*FIFO_WIDTH  per-producer word; producer i at bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-007 SHALL have port gnt  output  NUM_REQ  registered one-hot; gnt[i]=1 means producer i's word was taken at the previous edge.
REQ-008 SHALL have port wr_en  output  1  registered FIFO write enable.
REQ-009 SHALL have port data_in  output  FIFO_WIDTH  registered FIFO write data.
REQ-010 SHALL have ports full, almostfull, wr_ack, overflow  input  1 each  FIFO status; wr_ack and overflow describe the write sampled at the previous edge.
REQ-011 SHALL have port state  output  2  FSM state: 0 IDLE, 1 WRITE, 2 STALL.
REQ-012 SHALL have port err_ovf  output  1  sticky: FIFO reported overflow on an arbiter-issued write.
REQ-013 SHALL have port err_noack  output  1  sticky: arbiter-issued write got neither wr_ack nor overflow.
REQ-014 SHALL have port wr_count  output  16  count of acknowledged writes, wraps 0xFFFF->0.

Function
REQ-015 SHALL compute can_write = !full && !(almostfull && wr_en) each cycle; an in-flight write into the last free slot stalls further writes.
REQ-016 SHALL, at an edge with any req bit set and can_write=1, select one requester round-robin, drive wr_en<=1, data_in<=that word, gnt<=one-hot of it.
REQ-017 SHALL otherwise drive wr_en<=0, gnt<=0 and hold data_in.
REQ-018 SHALL search round-robin from the index after the last granted producer, wrapping NUM_REQ-1 -> 0; after reset the search starts at 0.
REQ-019 SHALL grant at most one producer per cycle; a producer held at req=1 receives back-to-back grants only when no other req is set.
REQ-020 SHALL never assert wr_en while full=1 was sampled at the same edge.
REQ-021 SHALL hold a 1-bit wr_pend = previous wr_en; at an edge with wr_pend=1: wr_ack=1 increments wr_count, overflow=1 sets err_ovf, neither sets err_noack.
REQ-022 SHALL ignore wr_ack/overflow at edges with wr_pend=0.
REQ-023 SHALL keep err_ovf and err_noack set until reset.
REQ-024 SHALL run FSM: IDLE no req; WRITE write issued this edge; STALL req pending and can_write=0.
REQ-025 SHALL transition at each edge from any state to WRITE if req!=0 and can_write, STALL if req!=0 and !can_write, else IDLE.
REQ-026 SHALL keep the round-robin pointer unchanged through STALL and IDLE cycles.
REQ-027 SHALL have one edge latency from sampled req to wr_en/gnt; producers may change req_data in the cycle gnt is high.

Reset
REQ-028 SHALL, at an edge with rst=1, force gnt=0, wr_en=0, data_in=0, state=IDLE, wr_pend=0, err_ovf=0, err_noack=0, wr_count=0, pointer=0, overriding all other activity, including a write in flight.

Verification
REQ-029 SHALL verify fairness: req=4'b1111, FIFO empty, 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and wr_count=8 after acks.
REQ-030 SHALL verify full stall: almostfull=1 and wr_en=1 with req=4'b0001 -> next cycle wr_en=0, state=STALL; full=1 held 3 cycles -> no wr_en; full drops -> wr_en resumes one edge later.
REQ-031 SHALL verify data routing: req=4'b0100, req_data word2=16'hA5A5 -> next cycle wr_en=1, data_in=16'hA5A5, gnt=4'b0100.
REQ-032 SHALL verify error flags: FIFO model returns overflow=1 for one write -> err_ovf=1 sticky; suppressed wr_ack and overflow -> err_noack=1; wr_count unchanged both times.
REQ-033 SHALL verify mid-operation reset: rst=1 during WRITE after grants to producers 0,1 -> all outputs zero next cycle, then req=4'b0011 grants producer 0 first.
REQ-034 SHALL verify counter wrap: preload via 65535 acked writes, one more ack -> wr_count=0, no error flags.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that merges NUM_REQ producers onto one FIFO write port.
// It tracks write acknowledgement, sticky error flags and a running count of acked writes.
module fifo_wr_arbiter #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          full,
  input  logic                          almostfull,
  input  logic                          wr_ack,
  input  logic                          overflow,
  output logic [1:0]                    state,
  output logic                          err_ovf,
  output logic                          err_noack,
  output logic [15:0]                   wr_count
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StStall = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic                    wr_pend_q, wr_pend_d;
  logic                    err_ovf_q, err_ovf_d;
  logic                    err_noack_q, err_noack_d;
  logic [15:0]             wr_count_q, wr_count_d;
  logic [PtrW-1:0]         ptr_q, ptr_d;

  logic                    found;
  logic [PtrW-1:0]         sel;
  logic                    can_write;
  logic                    issue;

  // Search starts at ptr_q, the index just after the last granted producer.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      int              idx;
      logic [PtrW-1:0] idx_v;
      idx = int'(ptr_q) + k;
      if (idx >= int'(NUM_REQ)) begin
        idx = idx - int'(NUM_REQ);
      end
      idx_v = PtrW'(idx);
      if (!found && req[idx_v]) begin
        found = 1'b1;
        sel   = idx_v;
      end
    end
  end

  // A write already in flight may consume the last free slot.
  assign can_write = !full && !(almostfull && wr_en_q);
  assign issue     = found && can_write;

  always_comb begin
    gnt_d       = '0;
    wr_en_d     = 1'b0;
    data_d      = data_q;
    ptr_d       = ptr_q;
    state_d     = StIdle;
    wr_pend_d   = wr_en_q;
    err_ovf_d   = err_ovf_q;
    err_noack_d = err_noack_q;
    wr_count_d  = wr_count_q;

    if (issue) begin
      gnt_d   = NUM_REQ'(1) << sel;
      wr_en_d = 1'b1;
      data_d  = req_data[sel*FIFO_WIDTH +: FIFO_WIDTH];
      ptr_d   = (sel == PtrW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      state_d = StWrite;
    end else if (found) begin
      state_d = StStall;
    end

    // FIFO status only refers to our own write from the previous cycle.
    if (wr_pend_q) begin
      if (wr_ack) begin
        wr_count_d = wr_count_q + 16'd1;
      end
      if (overflow) begin
        err_ovf_d = 1'b1;
      end
      if (!wr_ack && !overflow) begin
        err_noack_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      wr_en_q     <= 1'b0;
      data_q      <= '0;
      ptr_q       <= '0;
      wr_pend_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_noack_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wr_en_q     <= wr_en_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      wr_pend_q   <= wr_pend_d;
      err_ovf_q   <= err_ovf_d;
      err_noack_q <= err_noack_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign gnt       = gnt_q;
  assign wr_en     = wr_en_q;
  assign data_in   = data_q;
  assign state     = state_q;
  assign err_ovf   = err_ovf_q;
  assign err_noack = err_noack_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter; the bench acts as a FIFO that acks or
// flags overflow one cycle after each sampled write.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_data;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [15:0] data_in;
  logic        full;
  logic        almostfull;
  logic        wr_ack;
  logic        overflow;
  logic [1:0]  state;
  logic        err_ovf;
  logic        err_noack;
  logic [15:0] wr_count;

  logic        ack_en;
  logic        ovf_en;
  int          n_checks;
  int          n_fails;
  logic [15:0] words [4];

  fifo_wr_arbiter #(
    .FIFO_WIDTH(16),
    .NUM_REQ   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .full      (full),
    .almostfull(almostfull),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .state     (state),
    .err_ovf   (err_ovf),
    .err_noack (err_noack),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; FIFO response to the write sampled at that edge follows #1 later.
  task automatic tick();
    logic pend;
    pend = wr_en;
    @(posedge clk);
    #1;
    wr_ack   = pend & ack_en;
    overflow = pend & ovf_en;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drain();
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    req        = 4'b0000;
    words[0]   = 16'hC000;
    words[1]   = 16'hB001;
    words[2]   = 16'hA5A5;
    words[3]   = 16'hD003;
    req_data   = {16'hD003, 16'hA5A5, 16'hB001, 16'hC000};
    full       = 1'b0;
    almostfull = 1'b0;
    wr_ack     = 1'b0;
    overflow   = 1'b0;
    ack_en     = 1'b1;
    ovf_en     = 1'b0;

    tick();
    tick();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_data", 32'(data_in), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_flags", 32'({err_ovf, err_noack}), 32'h0);
    check("rst_count", 32'(wr_count), 32'h0);
    rst = 1'b0;

    // Fairness with all four producers requesting
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("fair_gnt", 32'(gnt), 32'd1 << (i % 4));
      check("fair_data", 32'(data_in), 32'(words[i % 4]));
      check("fair_wr_en", 32'(wr_en), 32'h1);
    end
    req = 4'b0000;
    tick();
    check("fair_idle_wr_en", 32'(wr_en), 32'h0);
    check("fair_idle_gnt", 32'(gnt), 32'h0);
    check("fair_idle_state", 32'(state), 32'h0);
    tick();
    tick();
    check("fair_count", 32'(wr_count), 32'd8);

    // Data routing from producer 2
    req = 4'b0100;
    tick();
    check("route_wr_en", 32'(wr_en), 32'h1);
    check("route_data", 32'(data_in), 32'hA5A5);
    check("route_gnt", 32'(gnt), 32'h4);
    check("route_state", 32'(state), 32'h1);
    req = 4'b0000;
    tick();
    check("route_hold_data", 32'(data_in), 32'hA5A5);
    check("route_off_wr_en", 32'(wr_en), 32'h0);

    // Pointer survives idle: next search starts after producer 2
    req = 4'b1111;
    tick();
    check("ptr_gnt3", 32'(gnt), 32'h8);
    tick();
    check("ptr_gnt0", 32'(gnt), 32'h1);
    req = 4'b0000;
    drain();
    check("ptr_count", 32'(wr_count), 32'd11);

    // Stall on almostfull with write in flight, then on full
    req = 4'b0001;
    tick();
    check("stall_first_wr", 32'(wr_en), 32'h1);
    almostfull = 1'b1;
    tick();
    check("stall_af_wr_en", 32'(wr_en), 32'h0);
    check("stall_af_state", 32'(state), 32'h2);
    check("stall_af_gnt", 32'(gnt), 32'h0);
    almostfull = 1'b0;
    full       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_full_wr_en", 32'(wr_en), 32'h0);
      check("stall_full_state", 32'(state), 32'h2);
    end
    full = 1'b0;
    tick();
    check("resume_wr_en", 32'(wr_en), 32'h1);
    check("resume_state", 32'(state), 32'h1);
    check("resume_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    check("resume_idle", 32'(state), 32'h0);
    tick();
    tick();
    check("stall_count", 32'(wr_count), 32'd13);

    // Overflow on one write
    ack_en = 1'b0;
    ovf_en = 1'b1;
    req    = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    check("ovf_flag", 32'(err_ovf), 32'h1);
    check("ovf_noack", 32'(err_noack), 32'h0);
    check("ovf_count", 32'(wr_count), 32'd13);
    ovf_en = 1'b0;
    ack_en = 1'b1;
    tick();
    check("ovf_sticky", 32'(err_ovf), 32'h1);

    // Write with neither ack nor overflow
    ack_en = 1'b0;
    req    = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    check("noack_flag", 32'(err_noack), 32'h1);
    check("noack_ovf_kept", 32'(err_ovf), 32'h1);
    check("noack_count", 32'(wr_count), 32'd13);
    ack_en = 1'b1;

    // Single requester gets back-to-back grants
    req = 4'b0010;
    tick();
    check("b2b_gnt_a", 32'(gnt), 32'h2);
    tick();
    check("b2b_gnt_b", 32'(gnt), 32'h2);
    req = 4'b0000;
    drain();

    // Reset in the middle of WRITE
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0011;
    tick();
    check("mid_gnt0", 32'(gnt), 32'h1);
    tick();
    check("mid_gnt1", 32'(gnt), 32'h2);
    check("mid_state", 32'(state), 32'h1);
    rst = 1'b1;
    tick();
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_wr_en", 32'(wr_en), 32'h0);
    check("mid_rst_data", 32'(data_in), 32'h0);
    check("mid_rst_state", 32'(state), 32'h0);
    check("mid_rst_flags", 32'({err_ovf, err_noack}), 32'h0);
    check("mid_rst_count", 32'(wr_count), 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_gnt0", 32'(gnt), 32'h1);
    check("post_rst_count", 32'(wr_count), 32'h0);
    tick();
    check("post_rst_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    drain();
    check("post_rst_total", 32'(wr_count), 32'd2);

    // Counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0001;
    for (int i = 0; i < 65535; i++) begin
      tick();
    end
    req = 4'b0000;
    drain();
    check("wrap_pre_count", 32'(wr_count), 32'hFFFF);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    drain();
    check("wrap_count", 32'(wr_count), 32'h0);
    check("wrap_flags", 32'({err_ovf, err_noack}), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
